simon_datapath: RTL and testbench

Datapath for a Simon memory game. It holds the sequence read/write address counters, level and max-score registers, the background select, an LFSR colour generator, a tone-period register and two interval timers. It decodes PS/2 keycodes into colour/enter events and raises compare flags for the game controller FSM. It drives an external 256x2 sequence RAM, the display (background, score digits) and an audio square-wave generator.

---
 rtl/simon_datapath.sv | 213 +++++++++++++++++++++
 tb/tb_simon_datapath.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_datapath.sv
// Datapath for the Simon memory game: address/score registers, key decode,
// LFSR colour source, tone period and two interval timers.
module simon_datapath #(
   parameter int MAX_LEVEL   = 99,
   parameter int WAIT_CYCLES = 25000000,
   parameter int DISP_CYCLES = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  dout,
   input  logic [7:0]  keycode,
   input  logic        make,
   input  logic        keycode_ready,
   input  logic        s_raddr,
   input  logic        en_raddr,
   input  logic        s_waddr,
   input  logic        en_waddr,
   input  logic        s_level,
   input  logic        en_level,
   input  logic        s_max_score,
   input  logic        en_max_score,
   input  logic [3:0]  s_bg,
   input  logic        en_bg,
   input  logic        en_rng,
   input  logic [2:0]  s_freq,
   input  logic        en_freq,
   input  logic        res_wait_timer,
   input  logic        res_disp_timer,
   output logic        enter_pressed,
   output logic        key_pressed,
   output logic        key_released,
   output logic        valid_input,
   output logic        red_pulse,
   output logic        green_pulse,
   output logic        yellow_pulse,
   output logic        blue_pulse,
   output logic        input_eq_red,
   output logic        input_eq_green,
   output logic        input_eq_yellow,
   output logic        input_eq_blue,
   output logic        raddr_eq_level,
   output logic        waddr_eq_max,
   output logic        raddr_eq_max,
   output logic        level_eq_max,
   output logic        correct,
   output logic        is_max_score,
   output logic        wait_timer_pulse,
   output logic        disp_timer_pulse,
   output logic        we,
   output logic [1:0]  din,
   output logic [7:0]  raddr,
   output logic [7:0]  waddr,
   output logic [2:0]  bg,
   output logic [4:0]  level_01,
   output logic [4:0]  level_10,
   output logic [4:0]  max_score_01,
   output logic [4:0]  max_score_10,
   output logic        audio_res,
   output logic [19:0] half_wav
);

   localparam logic [7:0]  KEY_RED    = 8'h15;
   localparam logic [7:0]  KEY_GREEN  = 8'h1D;
   localparam logic [7:0]  KEY_YELLOW = 8'h1C;
   localparam logic [7:0]  KEY_BLUE   = 8'h1B;
   localparam logic [7:0]  KEY_ENTER  = 8'h5A;
   localparam logic [7:0]  MAX_ADDR   = 8'(MAX_LEVEL);
   localparam logic [24:0] WAIT_LAST  = 25'(WAIT_CYCLES - 1);
   localparam logic [24:0] DISP_LAST  = 25'(DISP_CYCLES - 1);

   logic [15:0] lfsr;
   logic [7:0]  level;
   logic [7:0]  max_score;
   logic [24:0] wait_cnt;
   logic [24:0] disp_cnt;
   logic [1:0]  key_colour;
   logic        lfsr_fb;
   logic        unused_bg_msb;

   assign unused_bg_msb = s_bg[3];

   function automatic logic [4:0] digit_ones(input logic [7:0] x);
      logic [7:0] r;
      r = x % 8'd10;
      return r[4:0];
   endfunction

   function automatic logic [4:0] digit_tens(input logic [7:0] x);
      logic [7:0] r;
      r = (x / 8'd10) % 8'd10;
      return r[4:0];
   endfunction

   function automatic logic [19:0] tone_period(input logic [2:0] sel);
      logic [19:0] p;
      case (sel)
         3'd1:    p = 20'd80645;
         3'd2:    p = 20'd60241;
         3'd3:    p = 20'd99206;
         3'd4:    p = 20'd119617;
         3'd5:    p = 20'd595238;
         default: p = 20'd0;
      endcase
      return p;
   endfunction

   // Keycode decode and key events; independent of registered state except dout.
   always_comb begin
      input_eq_red    = (keycode == KEY_RED);
      input_eq_green  = (keycode == KEY_GREEN);
      input_eq_yellow = (keycode == KEY_YELLOW);
      input_eq_blue   = (keycode == KEY_BLUE);
      valid_input     = input_eq_red | input_eq_green | input_eq_yellow | input_eq_blue;
      if (input_eq_green) begin
         key_colour = 2'd1;
      end else if (input_eq_yellow) begin
         key_colour = 2'd2;
      end else if (input_eq_blue) begin
         key_colour = 2'd3;
      end else begin
         key_colour = 2'd0;
      end
      correct       = valid_input & (key_colour == dout);
      key_pressed   = keycode_ready & make;
      key_released  = keycode_ready & ~make;
      enter_pressed = key_pressed & (keycode == KEY_ENTER);
      red_pulse     = key_pressed & input_eq_red;
      green_pulse   = key_pressed & input_eq_green;
      yellow_pulse  = key_pressed & input_eq_yellow;
      blue_pulse    = key_pressed & input_eq_blue;
   end

   // Compare flags, display digits and tone-silence decode.
   always_comb begin
      is_max_score   = (level > max_score);
      raddr_eq_level = (raddr == level);
      raddr_eq_max   = (raddr == MAX_ADDR);
      waddr_eq_max   = (waddr == MAX_ADDR);
      level_eq_max   = (level == MAX_ADDR);
      level_01       = digit_ones(level);
      level_10       = digit_tens(level);
      max_score_01   = digit_ones(max_score);
      max_score_10   = digit_tens(max_score);
      we             = en_waddr & s_waddr;
      audio_res      = (half_wav == 20'd0);
      lfsr_fb        = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
   end

   // Sequence addresses, score registers, RNG, background and tone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         raddr     <= 8'd0;
         waddr     <= 8'd0;
         level     <= 8'd0;
         max_score <= 8'd0;
         lfsr      <= 16'hACE1;
         din       <= 2'd0;
         bg        <= 3'd0;
         half_wav  <= 20'd0;
      end else begin
         lfsr <= {lfsr_fb, lfsr[15:1]};
         if (en_raddr) raddr <= s_raddr ? raddr + 8'd1 : 8'd0;
         if (en_waddr) waddr <= s_waddr ? waddr + 8'd1 : 8'd0;
         // Level saturates so the score display never rolls back to zero.
         if (en_level) begin
            if (!s_level) begin
               level <= 8'd0;
            end else if (level != 8'hFF) begin
               level <= level + 8'd1;
            end
         end
         if (en_max_score) max_score <= s_max_score ? level : 8'd0;
         if (en_rng)       din       <= lfsr[1:0];
         if (en_bg)        bg        <= s_bg[2:0];
         if (en_freq)      half_wav  <= tone_period(s_freq);
      end
   end

   // Wait interval timer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt         <= 25'd0;
         wait_timer_pulse <= 1'b0;
      end else if (res_wait_timer) begin
         wait_cnt         <= 25'd0;
         wait_timer_pulse <= 1'b0;
      end else if (wait_cnt == WAIT_LAST) begin
         wait_cnt         <= 25'd0;
         wait_timer_pulse <= 1'b1;
      end else begin
         wait_cnt         <= wait_cnt + 25'd1;
         wait_timer_pulse <= 1'b0;
      end
   end

   // Display interval timer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_cnt         <= 25'd0;
         disp_timer_pulse <= 1'b0;
      end else if (res_disp_timer) begin
         disp_cnt         <= 25'd0;
         disp_timer_pulse <= 1'b0;
      end else if (disp_cnt == DISP_LAST) begin
         disp_cnt         <= 25'd0;
         disp_timer_pulse <= 1'b1;
      end else begin
         disp_cnt         <= disp_cnt + 25'd1;
         disp_timer_pulse <= 1'b0;
      end
   end

endmodule

// File: tb/tb_simon_datapath.sv
// Scoreboard bench for simon_datapath: stimulus pushes expectations at the
// falling edge, a monitor compares them just after the next rising edge.
module tb_simon_datapath;

   logic clk = 1'b0;
   logic rst;
   logic [1:0] dout;
   logic [7:0] keycode;
   logic make, keycode_ready;
   logic s_raddr, en_raddr, s_waddr, en_waddr;
   logic s_level, en_level, s_max_score, en_max_score;
   logic [3:0] s_bg;
   logic en_bg, en_rng;
   logic [2:0] s_freq;
   logic en_freq, res_wait_timer, res_disp_timer;
   logic enter_pressed, key_pressed, key_released, valid_input;
   logic red_pulse, green_pulse, yellow_pulse, blue_pulse;
   logic input_eq_red, input_eq_green, input_eq_yellow, input_eq_blue;
   logic raddr_eq_level, waddr_eq_max, raddr_eq_max, level_eq_max, correct, is_max_score;
   logic wait_timer_pulse, disp_timer_pulse, we, audio_res;
   logic [1:0] din;
   logic [7:0] raddr, waddr;
   logic [2:0] bg;
   logic [4:0] level_01, level_10, max_score_01, max_score_10;
   logic [19:0] half_wav;

   simon_datapath #(.MAX_LEVEL(99), .WAIT_CYCLES(4), .DISP_CYCLES(6)) dut (
      .clk(clk), .rst(rst), .dout(dout), .keycode(keycode), .make(make),
      .keycode_ready(keycode_ready), .s_raddr(s_raddr), .en_raddr(en_raddr),
      .s_waddr(s_waddr), .en_waddr(en_waddr), .s_level(s_level), .en_level(en_level),
      .s_max_score(s_max_score), .en_max_score(en_max_score), .s_bg(s_bg), .en_bg(en_bg),
      .en_rng(en_rng), .s_freq(s_freq), .en_freq(en_freq),
      .res_wait_timer(res_wait_timer), .res_disp_timer(res_disp_timer),
      .enter_pressed(enter_pressed), .key_pressed(key_pressed), .key_released(key_released),
      .valid_input(valid_input), .red_pulse(red_pulse), .green_pulse(green_pulse),
      .yellow_pulse(yellow_pulse), .blue_pulse(blue_pulse), .input_eq_red(input_eq_red),
      .input_eq_green(input_eq_green), .input_eq_yellow(input_eq_yellow),
      .input_eq_blue(input_eq_blue), .raddr_eq_level(raddr_eq_level),
      .waddr_eq_max(waddr_eq_max), .raddr_eq_max(raddr_eq_max), .level_eq_max(level_eq_max),
      .correct(correct), .is_max_score(is_max_score), .wait_timer_pulse(wait_timer_pulse),
      .disp_timer_pulse(disp_timer_pulse), .we(we), .din(din), .raddr(raddr), .waddr(waddr),
      .bg(bg), .level_01(level_01), .level_10(level_10), .max_score_01(max_score_01),
      .max_score_10(max_score_10), .audio_res(audio_res), .half_wav(half_wav)
   );

   always #5 clk = ~clk;

   typedef enum int {
      S_RADDR, S_WADDR, S_L01, S_L10, S_M01, S_M10, S_ISMAX, S_RAEL, S_RAEM, S_WAEM,
      S_LEM, S_HALF, S_AUDIO, S_BG, S_DIN, S_WE, S_WTP, S_DTP,
      S_EQ_R, S_EQ_G, S_EQ_Y, S_EQ_B, S_P_R, S_P_G, S_P_Y, S_P_B,
      S_VALID, S_CORRECT, S_KP, S_KR, S_ENTER
   } sig_e;

   typedef struct {
      string       name;
      sig_e        id;
      logic [31:0] exp;
   } item_t;

   item_t sb[$];
   item_t mon_item;
   int checks = 0;
   int errors = 0;
   logic [31:0] act;
   logic [15:0] lfsr_m;
   logic [1:0]  din_exp;

   function automatic logic [31:0] get_sig(sig_e id);
      case (id)
         S_RADDR:   return 32'(raddr);
         S_WADDR:   return 32'(waddr);
         S_L01:     return 32'(level_01);
         S_L10:     return 32'(level_10);
         S_M01:     return 32'(max_score_01);
         S_M10:     return 32'(max_score_10);
         S_ISMAX:   return 32'(is_max_score);
         S_RAEL:    return 32'(raddr_eq_level);
         S_RAEM:    return 32'(raddr_eq_max);
         S_WAEM:    return 32'(waddr_eq_max);
         S_LEM:     return 32'(level_eq_max);
         S_HALF:    return 32'(half_wav);
         S_AUDIO:   return 32'(audio_res);
         S_BG:      return 32'(bg);
         S_DIN:     return 32'(din);
         S_WE:      return 32'(we);
         S_WTP:     return 32'(wait_timer_pulse);
         S_DTP:     return 32'(disp_timer_pulse);
         S_EQ_R:    return 32'(input_eq_red);
         S_EQ_G:    return 32'(input_eq_green);
         S_EQ_Y:    return 32'(input_eq_yellow);
         S_EQ_B:    return 32'(input_eq_blue);
         S_P_R:     return 32'(red_pulse);
         S_P_G:     return 32'(green_pulse);
         S_P_Y:     return 32'(yellow_pulse);
         S_P_B:     return 32'(blue_pulse);
         S_VALID:   return 32'(valid_input);
         S_CORRECT: return 32'(correct);
         S_KP:      return 32'(key_pressed);
         S_KR:      return 32'(key_released);
         S_ENTER:   return 32'(enter_pressed);
         default:   return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic expect_sig(input string name, input sig_e id, input logic [31:0] exp);
      item_t it;
      it.name = name;
      it.id   = id;
      it.exp  = exp;
      sb.push_back(it);
   endtask

   // Reference LFSR (taps 16,14,13,11, right-shifting Fibonacci form)
   always @(posedge clk or posedge rst) begin
      if (rst) lfsr_m <= 16'hACE1;
      else     lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
   end

   // Monitor: compare every pending expectation just after the rising edge
   always @(posedge clk) begin
      #1;
      while (sb.size() > 0) begin
         mon_item = sb.pop_front();
         act = get_sig(mon_item.id);
         checks++;
         if (act !== mon_item.exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", mon_item.name, act, mon_item.exp);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   logic [7:0]  keys [4];
   logic [19:0] tones [8];

   initial begin
      keys  = '{8'h15, 8'h1D, 8'h1C, 8'h1B};
      tones = '{20'd0, 20'd80645, 20'd60241, 20'd99206, 20'd119617, 20'd595238, 20'd0, 20'd0};
      rst = 1'b1; dout = 2'd0; keycode = 8'h00; make = 1'b0; keycode_ready = 1'b0;
      s_raddr = 1'b0; en_raddr = 1'b0; s_waddr = 1'b0; en_waddr = 1'b0;
      s_level = 1'b0; en_level = 1'b0; s_max_score = 1'b0; en_max_score = 1'b0;
      s_bg = 4'd0; en_bg = 1'b0; en_rng = 1'b0; s_freq = 3'd0; en_freq = 1'b0;
      res_wait_timer = 1'b1; res_disp_timer = 1'b1;

      // reset state
      expect_sig("rst_raddr", S_RADDR, 32'd0);
      expect_sig("rst_waddr", S_WADDR, 32'd0);
      expect_sig("rst_level01", S_L01, 32'd0);
      expect_sig("rst_half", S_HALF, 32'd0);
      expect_sig("rst_audio", S_AUDIO, 32'd1);
      expect_sig("rst_bg", S_BG, 32'd0);
      expect_sig("rst_din", S_DIN, 32'd0);
      expect_sig("rst_ismax", S_ISMAX, 32'd0);
      expect_sig("rst_wtp", S_WTP, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // level to 1
      en_level = 1'b1; s_level = 1'b1;
      expect_sig("lvl1_01", S_L01, 32'd1);
      expect_sig("lvl1_10", S_L10, 32'd0);
      expect_sig("lvl1_ismax", S_ISMAX, 32'd1);
      @(negedge clk);
      en_level = 1'b0;

      // raddr clear, then 256 increments with wrap
      en_raddr = 1'b1; s_raddr = 1'b0;
      expect_sig("raddr_clr", S_RADDR, 32'd0);
      expect_sig("raddr_clr_eql", S_RAEL, 32'd0);
      @(negedge clk);
      s_raddr = 1'b1;
      for (int i = 1; i <= 256; i++) begin
         expect_sig("raddr_inc", S_RADDR, 32'(i % 256));
         expect_sig("raddr_eq_level", S_RAEL, 32'(i == 1));
         expect_sig("raddr_eq_max", S_RAEM, 32'((i % 256) == 99));
         @(negedge clk);
      end
      en_raddr = 1'b0;

      // level up to 99, then saturation at 255
      en_level = 1'b1; s_level = 1'b1;
      for (int k = 2; k <= 300; k++) begin
         if (k == 47) begin
            expect_sig("lvl47_01", S_L01, 32'd7);
            expect_sig("lvl47_10", S_L10, 32'd4);
         end
         if (k == 99) begin
            expect_sig("lvl99_eqmax", S_LEM, 32'd1);
            expect_sig("lvl99_01", S_L01, 32'd9);
            expect_sig("lvl99_10", S_L10, 32'd9);
         end
         if (k == 123) begin
            expect_sig("lvl123_01", S_L01, 32'd3);
            expect_sig("lvl123_10", S_L10, 32'd2);
         end
         if (k == 300) begin
            expect_sig("lvl_sat_01", S_L01, 32'd5);
            expect_sig("lvl_sat_10", S_L10, 32'd5);
            expect_sig("lvl_sat_eqmax", S_LEM, 32'd0);
            expect_sig("lvl_sat_ismax", S_ISMAX, 32'd1);
         end
         @(negedge clk);
      end
      en_level = 1'b0;

      // max score load, level clear, max score clear
      en_max_score = 1'b1; s_max_score = 1'b1;
      expect_sig("max_ld_01", S_M01, 32'd5);
      expect_sig("max_ld_10", S_M10, 32'd5);
      expect_sig("max_ld_ismax", S_ISMAX, 32'd0);
      @(negedge clk);
      en_max_score = 1'b0; en_level = 1'b1; s_level = 1'b0;
      expect_sig("lvl_clr_01", S_L01, 32'd0);
      expect_sig("lvl_clr_ismax", S_ISMAX, 32'd0);
      expect_sig("max_hold_01", S_M01, 32'd5);
      @(negedge clk);
      en_level = 1'b0; en_max_score = 1'b1; s_max_score = 1'b0;
      expect_sig("max_clr_01", S_M01, 32'd0);
      expect_sig("max_clr_10", S_M10, 32'd0);
      @(negedge clk);
      en_max_score = 1'b0;

      // tone select
      en_freq = 1'b1; s_freq = 3'd2;
      expect_sig("freq_green", S_HALF, 32'd60241);
      expect_sig("freq_green_audio", S_AUDIO, 32'd0);
      @(negedge clk);
      s_freq = 3'd0;
      expect_sig("freq_off", S_HALF, 32'd0);
      expect_sig("freq_off_audio", S_AUDIO, 32'd1);
      @(negedge clk);
      for (int f = 0; f < 8; f++) begin
         s_freq = 3'(f);
         expect_sig("freq_table", S_HALF, 32'(tones[f]));
         expect_sig("freq_table_audio", S_AUDIO, 32'(tones[f] == 20'd0));
         @(negedge clk);
      end
      s_freq = 3'd4;
      @(negedge clk);
      en_freq = 1'b0; s_freq = 3'd1;
      expect_sig("freq_hold", S_HALF, 32'd119617);
      @(negedge clk);

      // key decode and events
      dout = 2'd1; keycode = 8'h1D; make = 1'b1; keycode_ready = 1'b0;
      expect_sig("key_eq_green", S_EQ_G, 32'd1);
      expect_sig("key_eq_red", S_EQ_R, 32'd0);
      expect_sig("key_valid", S_VALID, 32'd1);
      expect_sig("key_correct", S_CORRECT, 32'd1);
      expect_sig("key_noready_pulse", S_P_G, 32'd0);
      expect_sig("key_noready_kp", S_KP, 32'd0);
      @(negedge clk);
      keycode_ready = 1'b1;
      expect_sig("key_green_pulse", S_P_G, 32'd1);
      expect_sig("key_pressed", S_KP, 32'd1);
      expect_sig("key_not_enter", S_ENTER, 32'd0);
      @(negedge clk);
      keycode_ready = 1'b0; dout = 2'd2;
      expect_sig("key_wrong_colour", S_CORRECT, 32'd0);
      @(negedge clk);
      keycode = 8'h5A; keycode_ready = 1'b1;
      expect_sig("enter_pressed", S_ENTER, 32'd1);
      expect_sig("enter_not_valid", S_VALID, 32'd0);
      expect_sig("enter_not_correct", S_CORRECT, 32'd0);
      @(negedge clk);
      make = 1'b0;
      expect_sig("enter_break", S_ENTER, 32'd0);
      expect_sig("key_released", S_KR, 32'd1);
      expect_sig("break_not_pressed", S_KP, 32'd0);
      @(negedge clk);
      make = 1'b1;
      for (int c = 0; c < 4; c++) begin
         keycode = keys[c]; dout = 2'(c);
         expect_sig("colour_correct", S_CORRECT, 32'd1);
         expect_sig("colour_eq", sig_e'(S_EQ_R + c), 32'd1);
         expect_sig("colour_pulse", sig_e'(S_P_R + c), 32'd1);
         expect_sig("colour_other_pulse", sig_e'(S_P_R + ((c + 1) % 4)), 32'd0);
         @(negedge clk);
      end
      keycode_ready = 1'b0; keycode = 8'h00; dout = 2'd0;

      // background
      en_bg = 1'b1; s_bg = 4'd5;
      expect_sig("bg_load", S_BG, 32'd5);
      @(negedge clk);
      en_bg = 1'b0; s_bg = 4'd2;
      expect_sig("bg_hold", S_BG, 32'd5);
      @(negedge clk);
      en_bg = 1'b1; s_bg = 4'hE;
      expect_sig("bg_truncate", S_BG, 32'd6);
      @(negedge clk);
      en_bg = 1'b0;

      // RNG capture against the reference LFSR
      for (int r = 0; r < 3; r++) begin
         repeat (r + 1) @(negedge clk);
         en_rng = 1'b1;
         din_exp = lfsr_m[1:0];
         expect_sig("rng_din", S_DIN, 32'(din_exp));
         @(negedge clk);
         en_rng = 1'b0;
         expect_sig("rng_hold", S_DIN, 32'(din_exp));
         @(negedge clk);
      end

      // write address and write enable
      en_waddr = 1'b1; s_waddr = 1'b0;
      expect_sig("waddr_clr", S_WADDR, 32'd0);
      expect_sig("we_clr", S_WE, 32'd0);
      @(negedge clk);
      s_waddr = 1'b1;
      for (int w = 1; w <= 99; w++) begin
         expect_sig("we_inc", S_WE, 32'd1);
         expect_sig("waddr_inc", S_WADDR, 32'(w));
         expect_sig("waddr_eq_max", S_WAEM, 32'(w == 99));
         @(negedge clk);
      end
      en_waddr = 1'b0;
      expect_sig("we_idle", S_WE, 32'd0);
      expect_sig("waddr_hold", S_WADDR, 32'd99);
      @(negedge clk);

      // timers released together; pulses every 4th / 6th cycle
      res_wait_timer = 1'b0; res_disp_timer = 1'b0;
      for (int t = 1; t <= 14; t++) begin
         expect_sig("wait_pulse", S_WTP, 32'((t % 4) == 0));
         expect_sig("disp_pulse", S_DTP, 32'((t % 6) == 0));
         @(negedge clk);
      end
      res_wait_timer = 1'b1; res_disp_timer = 1'b1;
      for (int t = 0; t < 6; t++) begin
         expect_sig("wait_held", S_WTP, 32'd0);
         expect_sig("disp_held", S_DTP, 32'd0);
         @(negedge clk);
      end

      // asynchronous reset mid-cycle
      #2;
      rst = 1'b1;
      expect_sig("arst_waddr", S_WADDR, 32'd0);
      expect_sig("arst_bg", S_BG, 32'd0);
      expect_sig("arst_half", S_HALF, 32'd0);
      expect_sig("arst_audio", S_AUDIO, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
